math_seq_8bit: RTL and testbench
================================

Name: math_seq_8bit

Overview:
- Multi-cycle sequencer that drives one shared 8-bit add/sub unit to execute ADD, SUB, MUL (8x8->16) and DIV (8/8 quotient+remainder).
- Sits between the instruction decode/execute stage and the add/sub unit.
- Owns operand/partial registers, iteration counter and a request/response handshake.
- The add/sub unit remains purely combinational and external.

Parameters:
- ITER, 8, iteration count for MUL/DIV; must equal the operand width and is fixed at 8 in this revision.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- req_a  input  8  operand A (multiplicand / dividend).
- req_b  input  8  operand B (multiplier / divisor).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_lo  output  8  low result byte.
- rsp_hi  output  8  high result byte.
- mu_a  output  8  add/sub unit operand a.
- mu_b  output  8  add/sub unit operand b.
- mu_sub  output  1  add/sub unit subtract select.
- mu_sum  input  8  add/sub unit result.

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1, rsp_valid=0, rsp_lo=rsp_hi=0, mu_a=mu_b=0, mu_sub=0; counter=0.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid: capture op, A, B; clear acc/rem; counter=0; go to EXEC.
- EXEC:
  - req_ready=0.
  - ADD/SUB take one cycle; MUL/DIV take exactly 8 cycles (counter 0..7).
  - Go to DONE after the last iteration.
- DONE:
  - rsp_valid=1; rsp_lo/rsp_hi stable.
  - On rsp_ready go to IDLE next cycle. A request is never accepted in the same cycle as a response handshake.
- Latency, accept edge to first rsp_valid cycle: ADD/SUB 2 cycles; MUL/DIV 9 cycles.
- Carry/borrow is derived locally; the unit supplies no carry output:
  - add carry = (mu_sum < mu_a)
  - sub borrow = (mu_a < mu_b)
- ADD: mu_a=A, mu_b=B, mu_sub=0; rsp_lo=mu_sum, rsp_hi={7'b0,carry}.
- SUB: mu_a=A, mu_b=B, mu_sub=1; rsp_lo=mu_sum (A-B mod 256), rsp_hi={7'b0,borrow}.
- MUL (shift-add, unsigned):
  - Registers: acc(8)=0, mpl(8)=B.
  - Each iteration: mu_a=acc, mu_b = mpl[0] ? A : 0, mu_sub=0.
  - {acc,mpl} <= {carry, mu_sum, mpl} >> 1, a 17-bit shift keeping the upper 16.
  - Result: rsp_hi=acc, rsp_lo=mpl.
- DIV (restoring, unsigned):
  - Registers: rem(8)=0, quo(8)=A.
  - Each iteration: mu_a={rem[6:0],quo[7]}, mu_b=B, mu_sub=1.
  - ge = rem[7] | (mu_a >= B).
  - rem <= ge ? mu_sum : mu_a; quo <= {quo[6:0],ge}.
  - Result: rsp_lo=quo, rsp_hi=rem.
- DIV by zero: runs the normal 8 iterations with no special path. Result is rsp_lo=0xFF, rsp_hi=A.
- mu_* outside EXEC: hold 0 (mu_sub=0).
- Operands change while busy: ignored; captured values are used.
- req_valid while not IDLE: not accepted; requester must hold the request.
- rsp_ready while not DONE: ignored.
- Reset mid-operation: in-flight result discarded; state IDLE immediately, all outputs at reset values.

Optional Feature:
- Macro MATH_SEQ_DIV0_FLAG_EN.
- Defined:
  - Extra output port div0 (1 bit).
  - Set in DONE when the op is DIV and B==0; 0 otherwise; reset 0.
  - div0 is valid with rsp_valid and cleared on return to IDLE.
- Not defined: port absent. DIV-by-zero result values are identical in both builds.

Test Plan:
- ADD A=0xF0 B=0x20 -> rsp_valid 2 cycles after accept, rsp_lo=0x10, rsp_hi=0x01; SUB A=0x05 B=0x07 -> rsp_lo=0xFE, rsp_hi=0x01.
- MUL A=0xFF B=0xFF -> rsp_valid 9 cycles after accept, {rsp_hi,rsp_lo}=0xFE01; MUL A=0x0D B=0x00 -> 0x0000.
- DIV A=0xC8 B=0x07 -> rsp_lo=0x1C, rsp_hi=0x04; DIV A=0xFF B=0x80 -> rsp_lo=0x01, rsp_hi=0x7F; DIV A=0x37 B=0x00 -> rsp_lo=0xFF, rsp_hi=0x37, div0=1 when macro defined.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid and data stable, req_ready=0, second req_valid not accepted; accepted only after rsp_ready and return to IDLE.
- Reset during MUL iteration 4 -> rsp_valid=0, req_ready=1 asynchronously; next ADD 0x01+0x01 returns 0x02 with no leftover state.
- Operand change: alter req_a/req_b every cycle during DIV 0x64/0x0A -> result stays rsp_lo=0x0A, rsp_hi=0x00.

Source files
------------

// File: rtl/math_seq_8bit.sv
// Multi-cycle ADD/SUB/MUL/DIV sequencer driving one shared external 8-bit add/sub unit.
// Optional div0 output enabled by defining MATH_SEQ_DIV0_FLAG_EN.
module math_seq_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_lo,
    output logic [7:0] rsp_hi,
    output logic [7:0] mu_a,
    output logic [7:0] mu_b,
    output logic       mu_sub,
    input  logic [7:0] mu_sum
`ifdef MATH_SEQ_DIV0_FLAG_EN
    ,
    output logic       div0
`endif
);

    localparam int unsigned W    = 8;
    localparam int unsigned ITER = 8;
    localparam int unsigned CW   = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;   // acc/mpl for MUL, rem/quo for DIV
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_lo_q, rsp_lo_d, rsp_hi_q, rsp_hi_d;
    logic [W-1:0]    mu_a_q, mu_a_d, mu_b_q, mu_b_d;
    logic            mu_sub_q, mu_sub_d;
    logic            div0_q, div0_d;
    logic            carry, borrow, ge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_lo_q    <= '0;
            rsp_hi_q    <= '0;
            mu_a_q      <= '0;
            mu_b_q      <= '0;
            mu_sub_q    <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_hi_q    <= rsp_hi_d;
            mu_a_q      <= mu_a_d;
            mu_b_q      <= mu_b_d;
            mu_sub_q    <= mu_sub_d;
            div0_q      <= div0_d;
        end
    end

    // Next state and datapath; mu_* are precomputed so they are registered for the cycle they apply to.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        rsp_lo_d = rsp_lo_q;
        rsp_hi_d = rsp_hi_q;
        mu_a_d   = '0;
        mu_b_d   = '0;
        mu_sub_d = 1'b0;
        carry    = (mu_sum < mu_a_q);
        borrow   = (mu_a_q < mu_b_q);
        ge       = hi_q[W-1] | (mu_a_q >= b_q);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = op_e'(req_op);
                    a_d     = req_a;
                    b_d     = req_b;
                    hi_d    = '0;
                    lo_d    = (op_e'(req_op) == OP_DIV) ? req_a : req_b;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q + CW'(1);
                case (op_q)
                    OP_ADD: begin
                        rsp_lo_d = mu_sum;
                        rsp_hi_d = {{(W-1){1'b0}}, carry};
                        state_d  = S_DONE;
                    end
                    OP_SUB: begin
                        rsp_lo_d = mu_sum;
                        rsp_hi_d = {{(W-1){1'b0}}, borrow};
                        state_d  = S_DONE;
                    end
                    OP_MUL: begin
                        hi_d = {carry, mu_sum[W-1:1]};
                        lo_d = {mu_sum[0], lo_q[W-1:1]};
                    end
                    default: begin
                        hi_d = ge ? mu_sum : mu_a_q;
                        lo_d = {lo_q[W-2:0], ge};
                    end
                endcase
                if ((op_q == OP_MUL || op_q == OP_DIV) && cnt_q == CW'(ITER - 1)) begin
                    rsp_hi_d = hi_d;
                    rsp_lo_d = lo_d;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_EXEC) begin
            case (op_d)
                OP_ADD: begin
                    mu_a_d = a_d;
                    mu_b_d = b_d;
                end
                OP_SUB: begin
                    mu_a_d   = a_d;
                    mu_b_d   = b_d;
                    mu_sub_d = 1'b1;
                end
                OP_MUL: begin
                    mu_a_d = hi_d;
                    mu_b_d = lo_d[0] ? a_d : '0;
                end
                default: begin
                    mu_a_d   = {hi_d[W-2:0], lo_d[W-1]};
                    mu_b_d   = b_d;
                    mu_sub_d = 1'b1;
                end
            endcase
        end

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
        div0_d      = (state_d == S_DONE) && (op_d == OP_DIV) && (b_d == '0);
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_lo    = rsp_lo_q;
    assign rsp_hi    = rsp_hi_q;
    assign mu_a      = mu_a_q;
    assign mu_b      = mu_b_q;
    assign mu_sub    = mu_sub_q;

`ifdef MATH_SEQ_DIV0_FLAG_EN
    assign div0 = div0_q;
`else
    logic unused_div0;
    assign unused_div0 = div0_q;
`endif

endmodule

// File: tb/tb_math_seq_8bit.sv
// Directed self-checking bench for math_seq_8bit with a behavioural add/sub unit attached.
// Checks div0 as well when MATH_SEQ_DIV0_FLAG_EN is defined.
module tb_math_seq_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [1:0] req_op;
    logic [7:0] req_a, req_b;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_lo, rsp_hi;
    logic [7:0] mu_a, mu_b, mu_sum;
    logic       mu_sub;
`ifdef MATH_SEQ_DIV0_FLAG_EN
    logic       div0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External combinational add/sub unit
    assign mu_sum = mu_sub ? (mu_a - mu_b) : (mu_a + mu_b);

    math_seq_8bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_lo    (rsp_lo),
        .rsp_hi    (rsp_hi),
        .mu_a      (mu_a),
        .mu_b      (mu_b),
        .mu_sub    (mu_sub),
        .mu_sum    (mu_sum)
`ifdef MATH_SEQ_DIV0_FLAG_EN
        ,
        .div0      (div0)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
        end
    endtask

    // Issue one request, check first-cycle mu drive, latency, result, then complete the handshake.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp_res, input int exp_lat,
                          input logic scramble);
        int guard = 0;
        int lat   = 0;
        logic [7:0] exp_mu_a;
        logic [7:0] exp_mu_b;
        exp_mu_a = (op == 2'd2) ? 8'h00 : (op == 2'd3) ? {7'b0, a[7]} : a;
        exp_mu_b = (op == 2'd2) ? (b[0] ? a : 8'h00) : b;
        @(negedge clk);
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, 16'(req_ready), 16'h1);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0;
                check({tag, "_mu_a"}, 16'(mu_a), 16'(exp_mu_a));
                check({tag, "_mu_b"}, 16'(mu_b), 16'(exp_mu_b));
                check({tag, "_mu_sub"}, 16'(mu_sub), 16'(op[0]));
            end
            if (scramble) begin
                req_a  = 8'($urandom);
                req_b  = 8'($urandom);
                req_op = 2'($urandom);
            end
        end while (!rsp_valid && lat < 30);
        check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
        check({tag, "_res"}, {rsp_hi, rsp_lo}, exp_res);
`ifdef MATH_SEQ_DIV0_FLAG_EN
        check({tag, "_div0"}, 16'(div0), 16'(op == 2'd3 && b == 8'h00));
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_idle_valid"}, 16'(rsp_valid), 16'h0);
        check({tag, "_idle_ready"}, 16'(req_ready), 16'h1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = 8'h00;
        req_b     = 8'h00;
        rsp_ready = 1'b0;
        #12;
        check("rst_ready", 16'(req_ready), 16'h1);
        check("rst_valid", 16'(rsp_valid), 16'h0);
        check("rst_rsp", {rsp_hi, rsp_lo}, 16'h0000);
        check("rst_mu", {mu_a, mu_b}, 16'h0000);
        check("rst_mu_sub", 16'(mu_sub), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_carry", 2'd0, 8'hF0, 8'h20, 16'h0110, 2, 1'b0);
        run_op("sub_borrow", 2'd1, 8'h05, 8'h07, 16'h01FE, 2, 1'b0);
        run_op("mul_ff", 2'd2, 8'hFF, 8'hFF, 16'hFE01, 9, 1'b0);
        run_op("mul_zero", 2'd2, 8'h0D, 8'h00, 16'h0000, 9, 1'b0);
        run_op("mul_0d_0b", 2'd2, 8'h0D, 8'h0B, 16'h008F, 9, 1'b0);
        run_op("div_c8_07", 2'd3, 8'hC8, 8'h07, 16'h041C, 9, 1'b0);
        run_op("div_ff_80", 2'd3, 8'hFF, 8'h80, 16'h7F01, 9, 1'b0);
        run_op("div_by0", 2'd3, 8'h37, 8'h00, 16'h37FF, 9, 1'b0);
        run_op("div_scramble", 2'd3, 8'h64, 8'h0A, 16'h000A, 9, 1'b1);

        // Backpressure: response held, second request waits until after the handshake
        @(negedge clk);
        req_op    = 2'd0;
        req_a     = 8'h30;
        req_b     = 8'h12;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_op = 2'd1;
        req_a  = 8'h10;
        req_b  = 8'h01;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 16'(rsp_valid), 16'h1);
            check("bp_data", {rsp_hi, rsp_lo}, 16'h0042);
            check("bp_ready", 16'(req_ready), 16'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_release_valid", 16'(rsp_valid), 16'h0);
        check("bp_release_ready", 16'(req_ready), 16'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_second_busy", 16'(req_ready), 16'h0);
        @(negedge clk);
        check("bp_second_valid", 16'(rsp_valid), 16'h1);
        check("bp_second_res", {rsp_hi, rsp_lo}, 16'h000F);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Asynchronous reset during MUL iteration 4
        req_op    = 2'd2;
        req_a     = 8'h0D;
        req_b     = 8'h0B;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_valid", 16'(rsp_valid), 16'h0);
        check("rstmid_ready", 16'(req_ready), 16'h1);
        check("rstmid_mu", {mu_a, mu_b}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_after_rst", 2'd0, 8'h01, 8'h01, 16'h0002, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
